pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Hazard and forwarding controller for the 24-bit five-stage pipeline (F, D, E, M, W). It sits beside the decode-to-execute pipeline register, consumes that register's execute-stage control outputs, and drives the feedback path: stall and flush controls back into fetch, decode and the execute register, plus operand forwarding selects for the execute-stage SrcA and SrcB muxes. It keeps its own shadow pipeline of destination registers for E, M and W, so no other stage needs to report write-back state.

## Interface
- No parameters. Register address width is fixed at 4 bits (R0–R15); data width is not seen by this block.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra1D  in  4  decode-stage source register A address
- ra2D  in  4  decode-stage source register B address
- useRa1D  in  1  decode instruction actually reads ra1D
- useRa2D  in  1  decode instruction actually reads ra2D
- WA3E  in  4  execute-stage destination address (from decode-to-execute register)
- regWriteE  in  1  execute-stage register-write enable (from decode-to-execute register)
- memToRegE  in  1  execute-stage instruction is a load (from decode-to-execute register)
- PCSrcE  in  1  taken branch resolved in execute this cycle
- stallF  out  1  hold PC
- stallD  out  1  hold fetch-to-decode register
- flushD  out  1  bubble fetch-to-decode register
- flushE  out  1  bubble into execute on next edge
- forwardAE  out  2  SrcA select: 00 register file, 10 ALU result from M, 01 result from W
- forwardBE  out  2  SrcB select, same encoding

## Operation
- Internal state: ra1E_q, ra2E_q (4 b each), useA_q, useB_q, validE_q; shadow M: WA3M_q, regWriteM_q; shadow W: WA3W_q, regWriteW_q.
- Effective execute write: wrE = regWriteE & validE_q. A flushed slot never writes, forwards or causes a stall, even though the decode-to-execute register still holds stale control bits.
- Each edge (no rst):
  - ra1E_q/ra2E_q/useA_q/useB_q <= decode values.
  - validE_q <= ~flushE.
  - WA3M_q <= WA3E; regWriteM_q <= wrE.
  - WA3W_q <= WA3M_q; regWriteW_q <= regWriteM_q.
- Forwarding, per operand X in {A,B}, using ra1E_q/ra2E_q:
  - srcX == WA3M_q & regWriteM_q & useX_q -> 10.
  - Otherwise srcX == WA3W_q & regWriteW_q & useX_q -> 01.
  - Otherwise 00.
  - M has priority over W.
  - Any source equal to 4'hF (R15/PC) always selects 00.
- Load-use: lduse = memToRegE & wrE & WA3E != 4'hF & ((useRa1D & ra1D == WA3E) | (useRa2D & ra2D == WA3E)).
- Branch: PCSrcE & validE_q is a taken branch.
- Outputs:
  - Taken branch: flushD = 1, flushE = 1, stallF = 0, stallD = 0. Branch wins over load-use, since the decode instruction is squashed.
  - Else lduse: stallF = 1, stallD = 1, flushE = 1, flushD = 0.
  - Else all zero.
- R15 is never a hazard or forwarding target.

## Timing
- Stall, flush and forward outputs are combinational from inputs and registered state; zero-cycle latency to the consuming muxes and enables.
- Load-use stall lasts exactly one cycle. Next cycle validE_q = 0, so wrE = 0 and lduse drops; the load then sits in M and its consumer gets 10, or 01 one cycle later.
- Taken branch: one cycle of flushD/flushE. The instruction entering E next cycle is a bubble (validE_q = 0), so a PCSrcE left asserted in stale control bits is ignored.
- Reset (synchronous): all state cleared, including validE_q = 0. During and after reset forwardAE = forwardBE = 00. Stall and flush outputs are 0, because validE_q = 0 masks regWriteE and PCSrcE.
- Reset mid-stall: the next cycle comes up with a clean state; no residual stall.
- Back-to-back loads into the same register: each produces its own one-cycle stall.

## Test plan
- Reset: hold rst 2 cycles with regWriteE = 1, PCSrcE = 1 -> all outputs 0 on the cycle after rst; on the first cycle after release, PCSrcE is still masked by validE_q = 0.
- ALU-ALU forward: E writes R3 (regWriteE = 1); next cycle decode reads ra1 = R3 -> forwardAE = 10 when consumer in E; a one-instruction gap gives 01.
- M/W priority: R5 written in both M and W, consumer reads R5 on B -> forwardBE = 10.
- Load-use: memToRegE = 1, WA3E = R2, ra2D = R2, useRa2D = 1 -> stallF = stallD = flushE = 1 for exactly 1 cycle; two cycles later forwardBE = 01.
- Branch plus load-use same cycle: PCSrcE = 1 with load-use condition -> flushD = flushE = 1, stallF = stallD = 0; following cycle all 0.
- R15 exclusion: regWriteE = 1, WA3E = 4'hF, ra1D = 4'hF, useRa1D = 1, load -> no stall; forwardAE = 00 when in E.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the five-stage pipeline (F, D, E, M, W).
// Keeps its own shadow copy of E/M/W destination state so no later stage reports back.
module pipeline_hazard_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ra1D,
    input  logic [3:0] ra2D,
    input  logic       useRa1D,
    input  logic       useRa2D,
    input  logic [3:0] WA3E,
    input  logic       regWriteE,
    input  logic       memToRegE,
    input  logic       PCSrcE,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE
);
    localparam logic [3:0] PC_REG = 4'hF;

    logic [3:0] ra1_e_r;
    logic [3:0] ra2_e_r;
    logic       use_a_r;
    logic       use_b_r;
    logic       valid_e_r;
    logic [3:0] wa3_m_r;
    logic       reg_write_m_r;
    logic [3:0] wa3_w_r;
    logic       reg_write_w_r;

    logic       wr_e_s;
    logic       branch_s;
    logic       lduse_s;

    // R15 is the PC, never a forwarding source; the younger writer in M beats W.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       use_src,
        input logic [3:0] wa3_m,
        input logic       wr_m,
        input logic [3:0] wa3_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        if (!use_src || (src == PC_REG)) begin
            sel = 2'b00;
        end else if (wr_m && (src == wa3_m)) begin
            sel = 2'b10;
        end else if (wr_w && (src == wa3_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Shadow pipeline: execute-stage sources plus M/W destination tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra1_e_r       <= 4'h0;
            ra2_e_r       <= 4'h0;
            use_a_r       <= 1'b0;
            use_b_r       <= 1'b0;
            valid_e_r     <= 1'b0;
            wa3_m_r       <= 4'h0;
            reg_write_m_r <= 1'b0;
            wa3_w_r       <= 4'h0;
            reg_write_w_r <= 1'b0;
        end else begin
            ra1_e_r       <= ra1D;
            ra2_e_r       <= ra2D;
            use_a_r       <= useRa1D;
            use_b_r       <= useRa2D;
            valid_e_r     <= ~flushE;
            wa3_m_r       <= WA3E;
            reg_write_m_r <= wr_e_s;
            wa3_w_r       <= wa3_m_r;
            reg_write_w_r <= reg_write_m_r;
        end
    end

    // Stall/flush decision and forwarding selects; a bubbled E slot masks its stale control bits.
    always_comb begin
        wr_e_s   = regWriteE & valid_e_r;
        branch_s = PCSrcE & valid_e_r;
        lduse_s  = memToRegE & wr_e_s & (WA3E != PC_REG) &
                   ((useRa1D & (ra1D == WA3E)) | (useRa2D & (ra2D == WA3E)));

        if (branch_s) begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lduse_s) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushD = 1'b0;
            flushE = 1'b1;
        end else begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b0;
            flushE = 1'b0;
        end

        forwardAE = fwd_sel(ra1_e_r, use_a_r, wa3_m_r, reg_write_m_r, wa3_w_r, reg_write_w_r);
        forwardBE = fwd_sel(ra2_e_r, use_b_r, wa3_m_r, reg_write_m_r, wa3_w_r, reg_write_w_r);
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed vector table plus randomized traffic,
// both compared against a cycle-history reference model.
module tb_pipeline_hazard_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra1D, ra2D, WA3E;
    logic       useRa1D, useRa2D, regWriteE, memToRegE, PCSrcE;
    logic       stallF, stallD, flushD, flushE;
    logic [1:0] forwardAE, forwardBE;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .useRa1D(useRa1D), .useRa2D(useRa2D),
        .WA3E(WA3E), .regWriteE(regWriteE), .memToRegE(memToRegE), .PCSrcE(PCSrcE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE)
    );

    typedef struct {
        logic       rst;
        logic [3:0] ra1;
        logic       u1;
        logic [3:0] ra2;
        logic       u2;
        logic [3:0] wa3;
        logic       rw;
        logic       mtr;
        logic       pcs;
    } stim_t;

    typedef struct {
        stim_t      s;
        bit         chk;
        logic [7:0] exp;   // {stallF, stallD, flushD, flushE, forwardAE, forwardBE}
    } vec_t;

    localparam int MAXC = 1024;
    stim_t hist[MAXC];
    bit    wr_hist[MAXC];
    bit    fl_hist[MAXC];
    vec_t  vecs[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    // Reference forward select: consumer was decoded last cycle; M holds the
    // instruction that was in E last cycle, W the one from two cycles ago.
    function automatic logic [1:0] model_fwd(input int c, input bit op_a);
        logic [3:0] src;
        bit         use_it;
        if (c < 1) return 2'b00;
        if (hist[c-1].rst) return 2'b00;
        src    = op_a ? hist[c-1].ra1 : hist[c-1].ra2;
        use_it = op_a ? hist[c-1].u1  : hist[c-1].u2;
        if (!use_it || src == 4'hF) return 2'b00;
        if (wr_hist[c-1] && hist[c-1].wa3 == src) return 2'b10;
        if (c >= 2) begin
            if (wr_hist[c-2] && !hist[c-2].rst && hist[c-2].wa3 == src) return 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic step(input stim_t s, input bit chk, input logic [7:0] exp);
        logic [7:0] got, mdl;
        bit valid, wr, taken, ld;
        rst = s.rst; ra1D = s.ra1; useRa1D = s.u1; ra2D = s.ra2; useRa2D = s.u2;
        WA3E = s.wa3; regWriteE = s.rw; memToRegE = s.mtr; PCSrcE = s.pcs;
        #2;
        got = {stallF, stallD, flushD, flushE, forwardAE, forwardBE};
        valid = 1'b0;
        if (cyc >= 1) valid = !hist[cyc-1].rst && !fl_hist[cyc-1];
        hist[cyc] = s;
        wr    = s.rw && valid;
        taken = s.pcs && valid;
        ld    = s.mtr && wr && (s.wa3 != 4'hF) &&
                ((s.u1 && s.ra1 == s.wa3) || (s.u2 && s.ra2 == s.wa3));
        wr_hist[cyc] = wr;
        fl_hist[cyc] = taken || ld;
        mdl = {!taken && ld, !taken && ld, taken, taken || ld,
               model_fwd(cyc, 1'b1), model_fwd(cyc, 1'b0)};
        if (cyc >= 1) begin
            n_tests++;
            if (got !== mdl) begin
                n_fail++;
                $display("FAIL model cyc %0d: got %b expected %b", cyc, got, mdl);
            end
        end
        if (chk) begin
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vector cyc %0d: got %b expected %b", cyc, got, exp);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic add(input logic r, input logic [3:0] ra1, input logic u1,
                       input logic [3:0] ra2, input logic u2, input logic [3:0] wa3,
                       input logic rw, input logic mtr, input logic pcs,
                       input bit chk, input logic [7:0] exp);
        vec_t v;
        v.s.rst = r; v.s.ra1 = ra1; v.s.u1 = u1; v.s.ra2 = ra2; v.s.u2 = u2;
        v.s.wa3 = wa3; v.s.rw = rw; v.s.mtr = mtr; v.s.pcs = pcs;
        v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] rand_reg();
        int unsigned r;
        logic [3:0] v;
        r = $urandom_range(0, 4);
        v = r[3:0];
        return (r == 4) ? 4'hF : v;
    endfunction

    initial begin
        stim_t s;
        // Reset held with stale write/branch bits, then released
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0000_00_00);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'b0000_00_00);
        // ALU-ALU forward: M then W
        add(1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_10_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_01_00);
        // M over W priority on operand B
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_00_10);
        // Load-use on B: one stall cycle, bubble with stale bits, then W forward
        add(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 8'b1101_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_00_10);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_00_01);
        // Branch and load-use together; stale branch bits then ignored
        add(1'b0, 4'h9, 1'b1, 4'h0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0011_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_10_00);
        // R15 is never a load-use or forwarding target
        add(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_00_00);
        // Back-to-back loads into R4, each with its own stall
        add(1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 8'b1101_00_00);
        add(1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_10_00);
        add(1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 8'b1101_01_00);
        add(1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_10_00);
        // Reset during a load-use stall leaves no residue
        add(1'b1, 4'h0, 1'b0, 4'h6, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 8'b1101_01_00);
        add(1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_00_00);
        add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_00_00);

        foreach (vecs[i]) step(vecs[i].s, vecs[i].chk, vecs[i].exp);

        // Randomized traffic over a small register set so hazards are frequent
        for (int i = 0; i < 500; i++) begin
            s.rst = ($urandom_range(0, 39) == 0);
            s.ra1 = rand_reg();
            s.u1  = $urandom_range(0, 1) == 1;
            s.ra2 = rand_reg();
            s.u2  = $urandom_range(0, 1) == 1;
            s.wa3 = rand_reg();
            s.rw  = $urandom_range(0, 3) != 0;
            s.mtr = $urandom_range(0, 1) == 1;
            s.pcs = $urandom_range(0, 7) == 0;
            step(s, 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
